// File: rtl/run_stream_source.sv
// Network input source: turns dense, sparse-spike, run-count and clear words
// from the host stream into registered network cycles and a one-cycle clear.
module run_stream_source #(
  parameter int  NUM_INP      = 4,
  parameter int  CHARGE_WIDTH = 8,
  parameter int  RUN_WIDTH    = 16,
  localparam int IDX_WIDTH    = (NUM_INP > 1) ? $clog2(NUM_INP) : 1,
  localparam int DENSE_W      = NUM_INP * CHARGE_WIDTH,
  localparam int SPK_W        = IDX_WIDTH + CHARGE_WIDTH,
  localparam int MAX_A        = (DENSE_W > SPK_W) ? DENSE_W : SPK_W,
  localparam int SRC_WIDTH    = 2 + ((MAX_A > RUN_WIDTH) ? MAX_A : RUN_WIDTH)
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           src_valid,
  output logic                           src_ready,
  input  logic [SRC_WIDTH-1:0]           src,
  input  logic                           net_ready,
  output logic                           net_valid,
  output logic                           net_last,
  output logic                           net_arstn,
  output logic signed [CHARGE_WIDTH-1:0] net_inp [0:NUM_INP-1]
);

  localparam logic [1:0] OP_NOM = 2'd0;
  localparam logic [1:0] OP_RUN = 2'd1;
  localparam logic [1:0] OP_CLR = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLR} state_e;

  state_e                          state_q, state_d;
  logic [RUN_WIDTH-1:0]            remaining_q, remaining_d;
  logic signed [CHARGE_WIDTH-1:0]  staging_q [0:NUM_INP-1];
  logic signed [CHARGE_WIDTH-1:0]  staging_d [0:NUM_INP-1];
  logic signed [CHARGE_WIDTH-1:0]  net_inp_q [0:NUM_INP-1];
  logic signed [CHARGE_WIDTH-1:0]  net_inp_d [0:NUM_INP-1];
  logic                            net_valid_q, net_valid_d;
  logic                            net_last_q, net_last_d;
  logic                            clr_n_q, clr_n_d;

  logic [1:0]                      src_op;
  logic [RUN_WIDTH-1:0]            run_cnt;
  logic [IDX_WIDTH-1:0]            spk_idx;
  logic signed [CHARGE_WIDTH-1:0]  spk_charge;
  logic signed [CHARGE_WIDTH-1:0]  dense_chg [0:NUM_INP-1];
  logic                            accept;
  logic                            out_free;

  assign src_op     = src[SRC_WIDTH-1 -: 2];
  assign run_cnt    = src[RUN_WIDTH-1:0];
  assign spk_idx    = src[SRC_WIDTH-3 -: IDX_WIDTH];
  assign spk_charge = src[SRC_WIDTH-3-IDX_WIDTH -: CHARGE_WIDTH];

  // Input 0 occupies the most significant charge field of the payload.
  for (genvar gi = 0; gi < NUM_INP; gi++) begin : g_lane
    assign dense_chg[gi] = src[SRC_WIDTH-3-gi*CHARGE_WIDTH -: CHARGE_WIDTH];
    assign net_inp[gi]   = net_inp_q[gi];
  end

  assign out_free  = !net_valid_q || net_ready;
  assign src_ready = (state_q == S_IDLE) && out_free;
  assign accept    = src_valid && src_ready;
  assign net_valid = net_valid_q;
  assign net_last  = net_last_q;
  assign net_arstn = arstn && clr_n_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    staging_d   = staging_q;
    net_inp_d   = net_inp_q;
    net_valid_d = net_valid_q;
    net_last_d  = net_last_q;
    clr_n_d     = 1'b1;

    if (net_valid_q && net_ready) begin
      net_valid_d = 1'b0;
      net_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (src_op)
            OP_NOM: begin
              net_inp_d   = dense_chg;
              net_valid_d = 1'b1;
              net_last_d  = 1'b1;
              staging_d   = '{default: '0};
            end
            OP_RUN: begin
              // A zero count consumes the word and leaves staging intact.
              if (run_cnt != '0) begin
                net_inp_d   = staging_q;
                net_valid_d = 1'b1;
                net_last_d  = (run_cnt == RUN_WIDTH'(1));
                remaining_d = run_cnt - RUN_WIDTH'(1);
                staging_d   = '{default: '0};
                if (run_cnt != RUN_WIDTH'(1)) state_d = S_RUN;
              end
            end
            OP_CLR: begin
              staging_d = '{default: '0};
              clr_n_d   = 1'b0;
              state_d   = S_CLR;
            end
            default: begin
              // Out-of-range indices match no lane and are dropped.
              for (int i = 0; i < NUM_INP; i++) begin
                if (int'(spk_idx) == i) staging_d[i] = spk_charge;
              end
            end
          endcase
        end
      end
      S_RUN: begin
        if (net_valid_q && net_ready) begin
          net_inp_d   = '{default: '0};
          net_valid_d = 1'b1;
          net_last_d  = (remaining_q == RUN_WIDTH'(1));
          remaining_d = remaining_q - RUN_WIDTH'(1);
          if (remaining_q == RUN_WIDTH'(1)) state_d = S_IDLE;
        end
      end
      S_CLR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      net_valid_q <= 1'b0;
      net_last_q  <= 1'b0;
      clr_n_q     <= 1'b0;
      for (int i = 0; i < NUM_INP; i++) begin
        staging_q[i] <= '0;
        net_inp_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      net_valid_q <= net_valid_d;
      net_last_q  <= net_last_d;
      clr_n_q     <= clr_n_d;
      staging_q   <= staging_d;
      net_inp_q   <= net_inp_d;
    end
  end

endmodule

// File: tb/tb_run_stream_source.sv
// Directed bench for run_stream_source: default 4-input instance plus a
// 3-input instance used to exercise an out-of-range sparse index.
module tb_run_stream_source;

  logic               clk = 1'b0;
  logic               arstn;
  logic               src_valid;
  logic               src_ready;
  logic [33:0]        src;
  logic               net_ready;
  logic               net_valid;
  logic               net_last;
  logic               net_arstn;
  logic signed [7:0]  net_inp [0:3];
  logic [31:0]        inp_packed;

  logic               b_src_valid;
  logic               b_src_ready;
  logic [25:0]        b_src;
  logic               b_net_ready;
  logic               b_net_valid;
  logic               b_net_last;
  logic               b_net_arstn;
  logic signed [7:0]  b_net_inp [0:2];
  logic [23:0]        b_inp_packed;

  int compared   = 0;
  int mismatched = 0;
  int hs_count   = 0;
  int hs_start;

  always #5 clk = ~clk;

  run_stream_source dut (
    .clk       (clk),
    .arstn     (arstn),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src       (src),
    .net_ready (net_ready),
    .net_valid (net_valid),
    .net_last  (net_last),
    .net_arstn (net_arstn),
    .net_inp   (net_inp)
  );

  run_stream_source #(.NUM_INP(3)) dut_b (
    .clk       (clk),
    .arstn     (arstn),
    .src_valid (b_src_valid),
    .src_ready (b_src_ready),
    .src       (b_src),
    .net_ready (b_net_ready),
    .net_valid (b_net_valid),
    .net_last  (b_net_last),
    .net_arstn (b_net_arstn),
    .net_inp   (b_net_inp)
  );

  assign inp_packed   = {net_inp[0], net_inp[1], net_inp[2], net_inp[3]};
  assign b_inp_packed = {b_net_inp[0], b_net_inp[1], b_net_inp[2]};

  always @(posedge clk) if (net_valid && net_ready) hs_count++;

  function automatic logic [33:0] w_nom(input logic [7:0] a, b, c, d);
    return {2'd0, a, b, c, d};
  endfunction
  function automatic logic [33:0] w_run(input logic [15:0] n);
    return {2'd1, 16'h0000, n};
  endfunction
  function automatic logic [33:0] w_clr();
    return {2'd2, 32'h0000_0000};
  endfunction
  function automatic logic [33:0] w_spk(input logic [1:0] idx, input logic [7:0] ch);
    return {2'd3, idx, ch, 22'h0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    arstn = 1'b0; src_valid = 1'b0; src = '0; net_ready = 1'b0;
    b_src_valid = 1'b0; b_src = '0; b_net_ready = 1'b0;

    // Reset
    cyc(); cyc();
    chk("rst_valid", net_valid, 1'b0);
    chk("rst_last", net_last, 1'b0);
    chk("rst_arstn", net_arstn, 1'b0);
    chk("rst_inp", inp_packed, 32'h0);
    arstn = 1'b1;
    cyc();
    chk("rel_src_ready", src_ready, 1'b1);
    chk("rel_arstn", net_arstn, 1'b1);

    // Dense stream, one network cycle per clock
    net_ready = 1'b1; src_valid = 1'b1;
    src = w_nom(8'h01, 8'hFE, 8'h03, 8'hFC); cyc();
    chk("nom1_inp", inp_packed, 32'h01FE03FC);
    chk("nom1_vl", {net_valid, net_last}, 2'b11);
    src = w_nom(8'h05, 8'h06, 8'h07, 8'h08); cyc();
    chk("nom2_inp", inp_packed, 32'h05060708);
    chk("nom2_vl", {net_valid, net_last}, 2'b11);
    src = w_nom(8'h00, 8'h00, 8'h00, 8'h7F); cyc();
    chk("nom3_inp", inp_packed, 32'h0000007F);
    chk("nom3_vl", {net_valid, net_last}, 2'b11);
    src_valid = 1'b0; cyc();
    chk("nom_drain", net_valid, 1'b0);

    // Sparse staging then RUN 3, with RUN 1 queued behind it
    src_valid = 1'b1;
    src = w_spk(2'd2, 8'hFB); cyc();
    chk("spk_no_cycle", net_valid, 1'b0);
    src = w_spk(2'd0, 8'h09); cyc();
    src = w_run(16'd3); cyc();
    chk("run3_c1_inp", inp_packed, 32'h0900FB00);
    chk("run3_c1_vl", {net_valid, net_last}, 2'b10);
    src = w_run(16'd1);
    chk("run3_busy", src_ready, 1'b0);
    cyc();
    chk("run3_c2_inp", inp_packed, 32'h0);
    chk("run3_c2_vl", {net_valid, net_last}, 2'b10);
    cyc();
    chk("run3_c3_inp", inp_packed, 32'h0);
    chk("run3_c3_vl", {net_valid, net_last}, 2'b11);
    cyc();
    chk("run1_inp", inp_packed, 32'h0);
    chk("run1_vl", {net_valid, net_last}, 2'b11);
    src_valid = 1'b0; cyc();
    chk("run1_drain", net_valid, 1'b0);

    // Backpressure on RUN 2
    src_valid = 1'b1; src = w_spk(2'd1, 8'h33); cyc();
    net_ready = 1'b0; src = w_run(16'd2);
    hs_start = hs_count;
    cyc();
    src_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", net_valid, 1'b1);
      chk("bp_inp", inp_packed, 32'h00330000);
      chk("bp_src_ready", src_ready, 1'b0);
      cyc();
    end
    net_ready = 1'b1; cyc();
    chk("bp_c2", {net_valid, net_last, inp_packed}, {2'b11, 32'h0});
    cyc(); cyc();
    chk("bp_drain", net_valid, 1'b0);
    chk("bp_handshakes", hs_count - hs_start, 2);

    // CLR behind a pending NOM
    net_ready = 1'b0; src_valid = 1'b1;
    src = w_nom(8'h0A, 8'h14, 8'h1E, 8'h28); cyc();
    src = w_clr(); cyc();
    chk("clr_wait_rdy", src_ready, 1'b0);
    chk("clr_wait_arstn", net_arstn, 1'b1);
    chk("clr_wait_inp", inp_packed, 32'h0A141E28);
    net_ready = 1'b1; #1;
    chk("clr_rdy", src_ready, 1'b1);
    cyc();
    chk("clr_low", {net_arstn, net_valid}, 2'b00);
    src_valid = 1'b0; cyc();
    chk("clr_one_cycle", net_arstn, 1'b1);

    // CLR clears staging
    src_valid = 1'b1; src = w_spk(2'd3, 8'h55); cyc();
    src = w_clr(); cyc();
    chk("clr2_low", net_arstn, 1'b0);
    src = w_run(16'd1); cyc();
    chk("clr2_high", {net_arstn, net_valid}, 2'b10);
    cyc();
    chk("clr2_run_inp", inp_packed, 32'h0);
    chk("clr2_run_vl", {net_valid, net_last}, 2'b11);

    // SPK then NOM: staging cleared by the NOM
    src = w_spk(2'd0, 8'h11); cyc();
    src = w_nom(8'h01, 8'h02, 8'h03, 8'h04); cyc();
    chk("spknom_inp", inp_packed, 32'h01020304);
    src = w_run(16'd1); cyc();
    chk("spknom_run_inp", inp_packed, 32'h0);

    // RUN 0 is consumed without a network cycle
    src = w_run(16'd0); cyc();
    src_valid = 1'b0;
    chk("run0_valid", net_valid, 1'b0);
    chk("run0_ready", src_ready, 1'b1);
    cyc();
    chk("run0_still", net_valid, 1'b0);

    // Asynchronous reset in the middle of RUN 100
    src_valid = 1'b1; src = w_run(16'd100); cyc();
    src_valid = 1'b0; cyc(); cyc();
    chk("run100_valid", net_valid, 1'b1);
    #2 arstn = 1'b0;
    #1;
    chk("mid_rst_valid", net_valid, 1'b0);
    chk("mid_rst_arstn", net_arstn, 1'b0);
    cyc();
    arstn = 1'b1; cyc();
    src_valid = 1'b1; src = w_nom(8'h7F, 8'h80, 8'h01, 8'hFF); cyc();
    src_valid = 1'b0;
    chk("post_rst_inp", inp_packed, 32'h7F8001FF);
    chk("post_rst_vl", {net_valid, net_last, net_arstn}, 3'b111);
    cyc();
    chk("post_rst_drain", net_valid, 1'b0);

    // 3-input instance: index 3 is out of range and dropped
    b_net_ready = 1'b1; b_src_valid = 1'b1;
    b_src = {2'd3, 2'd3, 8'h01, 14'h0}; cyc();
    b_src = {2'd3, 2'd1, 8'hF9, 14'h0}; cyc();
    b_src = {2'd1, 8'h00, 16'd1}; cyc();
    b_src_valid = 1'b0;
    chk("b_run_inp", b_inp_packed, 24'h00F900);
    chk("b_run_vl", {b_net_valid, b_net_last}, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
